// File: rtl/video_frame_capture_pkg.sv
// Shared video timing definitions: FSM state encodings and default frame geometry.
// Also used by the generator side so both ends agree on the 2-bit state codes.
package video_frame_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int H_ACTIVE_DEF = 2448;
  localparam int V_ACTIVE_DEF = 2048;
  localparam int DATA_W_DEF   = 12;
  localparam int ADDR_W_DEF   = 23;
  localparam int CNT_W_DEF    = 13;

endpackage

// File: rtl/video_edge_detect.sv
// Two-stage input register with rise/fall pulses taken between the stages.
// Latency: s1 one cycle after the pin, pulses valid alongside s1; no backpressure.
module video_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s1,
  output logic rise,
  output logic fall
);

  logic s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign rise = s1 & ~s2;
  assign fall = ~s1 & s2;

endmodule

// File: rtl/video_frame_capture.sv
// Captures VSYNC/HSYNC-framed pixels into a linear frame-buffer write port and measures geometry.
// Latency: 2 cycles pin to wr_en/wr_data; no backpressure, the write port must accept every strobe.
module video_frame_capture
  import video_frame_capture_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              continuous,
  input  logic              VSYNC,
  input  logic              HSYNC,
  input  logic [DATA_W-1:0] pix_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  h_meas,
  output logic [CNT_W-1:0]  v_meas,
  output logic              len_err,
  output logic              cnt_err,
  output logic              ovr_err
);

  localparam logic [CNT_W-1:0]  H_C     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]  V_C     = CNT_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] H_A     = ADDR_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  state_t              state;
  logic                vs_s1, vs_rise, vs_fall;
  logic                hs_s1, hs_fall, unused_hs_rise;
  logic [DATA_W-1:0]   pix_s1;
  logic [CNT_W-1:0]    x, y;
  logic [ADDR_W-1:0]   addr, line_base;

  video_edge_detect u_vs (
    .clk  (clk),
    .rst  (rst),
    .d    (VSYNC),
    .s1   (vs_s1),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  video_edge_detect u_hs (
    .clk  (clk),
    .rst  (rst),
    .d    (HSYNC),
    .s1   (hs_s1),
    .rise (unused_hs_rise),
    .fall (hs_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pix_s1     <= '0;
      x          <= '0;
      y          <= '0;
      addr       <= '0;
      line_base  <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      h_meas     <= '0;
      v_meas     <= '0;
      len_err    <= 1'b0;
      cnt_err    <= 1'b0;
      ovr_err    <= 1'b0;
    end else begin
      pix_s1     <= pix_in;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arm) begin
            state <= ST_WAIT_VS;
            busy  <= 1'b1;
          end
        end
        // Only a rising VSYNC starts a capture, so a frame already in flight is skipped.
        ST_WAIT_VS: begin
          if (vs_rise) begin
            state     <= ST_CAPTURE;
            x         <= '0;
            y         <= '0;
            addr      <= '0;
            line_base <= '0;
            len_err   <= 1'b0;
            cnt_err   <= 1'b0;
            ovr_err   <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (vs_s1 && hs_s1) begin
            if (x < H_C && y < V_C) begin
              wr_en   <= 1'b1;
              wr_addr <= addr;
              wr_data <= pix_s1;
              addr    <= addr + 1'b1;
            end else begin
              ovr_err <= 1'b1;
            end
            x <= (x == CNT_MAX) ? x : x + 1'b1;
          end else if (hs_fall || (vs_fall && hs_s1)) begin
            // Closing here before the DONE hop lets v_meas count a line ending with VSYNC.
            h_meas    <= x;
            len_err   <= len_err | (x != H_C);
            y         <= (y == CNT_MAX) ? y : y + 1'b1;
            x         <= '0;
            line_base <= line_base + H_A;
            addr      <= line_base + H_A;
          end
          if (vs_fall) state <= ST_DONE;
        end
        ST_DONE: begin
          frame_done <= 1'b1;
          v_meas     <= y;
          cnt_err    <= (y != V_C);
          if (continuous) begin
            state <= ST_WAIT_VS;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_frame_capture.sv
// Scoreboard bench for video_frame_capture with an 8x4 frame: drivers queue expected writes/frames,
// negedge monitors pop and compare whenever wr_en or frame_done is presented.
module tb_video_frame_capture;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int DW = 12;
  localparam int AW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm, continuous, VSYNC, HSYNC;
  logic [DW-1:0] pix_in;
  logic          wr_en, busy, frame_done, len_err, cnt_err, ovr_err;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [CW-1:0] h_meas, v_meas;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int h;
    int v;
    bit len;
    bit cnt;
    bit ovr;
  } fr_t;

  wr_t exp_wr[$];
  fr_t exp_fr[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  video_frame_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .continuous (continuous),
    .VSYNC      (VSYNC),
    .HSYNC      (HSYNC),
    .pix_in     (pix_in),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done),
    .h_meas     (h_meas),
    .v_meas     (v_meas),
    .len_err    (len_err),
    .cnt_err    (cnt_err),
    .ovr_err    (ovr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_wr.size() == 0) begin
        check("unexpected_write_addr", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
  end

  // Frame-result monitor
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      if (exp_fr.size() == 0) begin
        check("unexpected_frame_done", 32'(v_meas), 32'hFFFF_FFFF);
      end else begin
        fr_t f;
        f = exp_fr.pop_front();
        check("h_meas",  32'(h_meas),  32'(f.h));
        check("v_meas",  32'(v_meas),  32'(f.v));
        check("len_err", 32'(len_err), 32'(f.len));
        check("cnt_err", 32'(cnt_err), 32'(f.cnt));
        check("ovr_err", 32'(ovr_err), 32'(f.ovr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  // One frame of nlines; line long_line has long_len pixels; pix = l*H+i+1.
  task automatic drive_frame(input int nlines, input int long_line, input int long_len,
                             input bit coincide, input bit expect_cap, input int arm_line,
                             input fr_t fres);
    int len;
    VSYNC = 1'b1;
    idle(3);
    for (int l = 0; l < nlines; l++) begin
      if (l == arm_line) pulse_arm();
      len = (l == long_line) ? long_len : H;
      for (int i = 0; i < len; i++) begin
        HSYNC  = 1'b1;
        pix_in = DW'(l * H + i + 1);
        if (expect_cap && i < H && l < V) exp_wr.push_back('{AW'(l * H + i), DW'(l * H + i + 1)});
        step();
      end
      if (expect_cap && l == nlines - 1) exp_fr.push_back(fres);
      if (coincide && l == nlines - 1) begin
        HSYNC = 1'b0;
        VSYNC = 1'b0;
      end else begin
        HSYNC = 1'b0;
        idle(2);
      end
    end
    VSYNC = 1'b0;
    idle(6);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; continuous = 1'b0;
    VSYNC = 1'b0; HSYNC = 1'b0; pix_in = '0;
    idle(3);
    check("rst_wr_en",      32'(wr_en),      0);
    check("rst_wr_addr",    32'(wr_addr),    0);
    check("rst_wr_data",    32'(wr_data),    0);
    check("rst_busy",       32'(busy),       0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_meas",       32'({h_meas, v_meas}), 0);
    check("rst_errs",       32'({len_err, cnt_err, ovr_err}), 0);
    rst = 1'b0;
    idle(2);

    // 1) clean single frame
    pulse_arm();
    idle(2);
    check("t1_busy_armed", 32'(busy), 1);
    drive_frame(4, -1, 0, 1'b0, 1'b1, -1, '{8, 4, 1'b0, 1'b0, 1'b0});
    check("t1_busy_after", 32'(busy), 0);

    // 2) arm mid-frame: that frame skipped, next captured
    drive_frame(4, -1, 0, 1'b0, 1'b0, 1, '{0, 0, 1'b0, 1'b0, 1'b0});
    check("t2_busy_waiting", 32'(busy), 1);
    drive_frame(4, -1, 0, 1'b0, 1'b1, -1, '{8, 4, 1'b0, 1'b0, 1'b0});
    check("t2_busy_after", 32'(busy), 0);

    // 3) line 2 is 10 pixels long
    pulse_arm();
    idle(2);
    drive_frame(4, 2, 10, 1'b0, 1'b1, -1, '{8, 4, 1'b1, 1'b0, 1'b1});

    // 4) 5-line frame in continuous mode, then a clean frame clears the errors
    continuous = 1'b1;
    pulse_arm();
    idle(2);
    drive_frame(5, -1, 0, 1'b0, 1'b1, -1, '{8, 5, 1'b0, 1'b1, 1'b1});
    check("t4_busy_rearmed", 32'(busy), 1);
    continuous = 1'b0;
    drive_frame(4, -1, 0, 1'b0, 1'b1, -1, '{8, 4, 1'b0, 1'b0, 1'b0});
    check("t4_busy_after", 32'(busy), 0);

    // 5) last hs_fall coincident with vs_fall
    pulse_arm();
    idle(2);
    drive_frame(4, -1, 0, 1'b1, 1'b1, -1, '{8, 4, 1'b0, 1'b0, 1'b0});

    // 6) reset mid-line
    pulse_arm();
    idle(2);
    VSYNC = 1'b1;
    idle(3);
    for (int i = 0; i < 6; i++) begin
      HSYNC  = 1'b1;
      pix_in = DW'(i + 1);
      if (i < 4) exp_wr.push_back('{AW'(i), DW'(i + 1)});
      step();
    end
    check("t6_wr_en_before_rst", 32'(wr_en), 1);
    #1 rst = 1'b1;
    #1;
    check("t6_wr_en_rst",  32'(wr_en), 0);
    check("t6_busy_rst",   32'(busy), 0);
    check("t6_addr_rst",   32'(wr_addr), 0);
    check("t6_meas_rst",   32'({h_meas, v_meas}), 0);
    check("t6_errs_rst",   32'({len_err, cnt_err, ovr_err}), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
    HSYNC = 1'b0;
    idle(2);
    for (int i = 0; i < H; i++) begin
      HSYNC  = 1'b1;
      pix_in = DW'(100 + i);
      step();
    end
    HSYNC = 1'b0;
    idle(2);
    VSYNC = 1'b0;
    idle(6);
    check("t6_busy_idle", 32'(busy), 0);

    idle(4);
    check("writes_outstanding", 32'(exp_wr.size()), 0);
    check("frames_outstanding", 32'(exp_fr.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
